// File: rtl/inverse_poly_solver.sv
// Sequential brute-force solver for (A*x*x + B*x + C) mod 256 == Y.
// Operands arrive over a go-handshake; candidates are tried from 0 upward, five cycles each.
module inverse_poly_solver #(
  parameter logic [7:0] XMAX = 8'd255
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic [7:0] data_in,
  output logic [7:0] x_result,
  output logic       found,
  output logic       done,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_LOAD_A      = 4'd0,
    S_LOAD_A_WAIT = 4'd1,
    S_LOAD_B      = 4'd2,
    S_LOAD_B_WAIT = 4'd3,
    S_LOAD_C      = 4'd4,
    S_LOAD_C_WAIT = 4'd5,
    S_LOAD_Y      = 4'd6,
    S_LOAD_Y_WAIT = 4'd7,
    S_EVAL_0      = 4'd8,
    S_EVAL_1      = 4'd9,
    S_EVAL_2      = 4'd10,
    S_EVAL_3      = 4'd11,
    S_CHECK       = 4'd12,
    S_DONE        = 4'd13,
    S_DONE_WAIT   = 4'd14
  } state_t;

  state_t     state, state_next;
  logic [7:0] a, b, c, y;
  logic [7:0] t, xc;
  logic       hit, last;

  assign hit  = (t == y);
  assign last = (xc == XMAX);

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_LOAD_A;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD_A:      if (go)  state_next = S_LOAD_A_WAIT;
      S_LOAD_A_WAIT: if (!go) state_next = S_LOAD_B;
      S_LOAD_B:      if (go)  state_next = S_LOAD_B_WAIT;
      S_LOAD_B_WAIT: if (!go) state_next = S_LOAD_C;
      S_LOAD_C:      if (go)  state_next = S_LOAD_C_WAIT;
      S_LOAD_C_WAIT: if (!go) state_next = S_LOAD_Y;
      S_LOAD_Y:      if (go)  state_next = S_LOAD_Y_WAIT;
      S_LOAD_Y_WAIT: if (!go) state_next = S_EVAL_0;
      S_EVAL_0:      state_next = S_EVAL_1;
      S_EVAL_1:      state_next = S_EVAL_2;
      S_EVAL_2:      state_next = S_EVAL_3;
      S_EVAL_3:      state_next = S_CHECK;
      S_CHECK:       state_next = (hit || last) ? S_DONE : S_EVAL_0;
      S_DONE:        if (go)  state_next = S_DONE_WAIT;
      S_DONE_WAIT:   if (!go) state_next = S_LOAD_A;
      default:       state_next = S_LOAD_A;
    endcase
  end

  // Horner form: t = ((A*x) + B)*x + C, one operation per cycle
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a        <= '0;
      b        <= '0;
      c        <= '0;
      y        <= '0;
      t        <= '0;
      xc       <= '0;
      x_result <= '0;
      found    <= 1'b0;
    end else begin
      case (state)
        S_LOAD_A: a <= data_in;
        S_LOAD_B: b <= data_in;
        S_LOAD_C: c <= data_in;
        S_LOAD_Y: y <= data_in;
        S_LOAD_Y_WAIT: begin
          if (!go) begin
            xc    <= '0;
            found <= 1'b0;
          end
        end
        S_EVAL_0: t <= a * xc;
        S_EVAL_1: t <= t + b;
        S_EVAL_2: t <= t * xc;
        S_EVAL_3: t <= t + c;
        S_CHECK: begin
          if (hit || last) begin
            x_result <= xc;
            found    <= hit;
          end else begin
            xc <= xc + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = (state == S_DONE) || (state == S_DONE_WAIT);
  assign busy = (state == S_EVAL_0) || (state == S_EVAL_1) || (state == S_EVAL_2) ||
                (state == S_EVAL_3) || (state == S_CHECK);

endmodule

// File: tb/tb_inverse_poly_solver.sv
// Bench for inverse_poly_solver: fixed vector table, mid-search reset, and random
// operands checked against a brute-force search model.
module tb_inverse_poly_solver;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       go = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic [7:0] x_result;
  logic       found, done, busy;

  int total = 0;
  int bad   = 0;

  inverse_poly_solver #(.XMAX(8'd255)) dut (
    .clk(clk), .resetn(resetn), .go(go), .data_in(data_in),
    .x_result(x_result), .found(found), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b, c, y;
    int hold;
    int ex, ef, ec;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Smallest x with the polynomial matching; done cycle is 5k+5, or 5*256 if none.
  function automatic void model(input int a, input int b, input int c, input int y,
                                output int x, output int f, output int cyc);
    x = 255; f = 0; cyc = 5 * 256;
    for (int k = 0; k < 256; k++) begin
      if (((a * k * k + b * k + c) % 256) == y) begin
        x = k; f = 1; cyc = 5 * k + 5;
        break;
      end
    end
  endfunction

  // One operand: present v, raise go, scramble data_in while go stays high, release.
  task automatic load_op(input logic [7:0] v, input int hold);
    @(negedge clk); data_in = v; go = 1'b0;
    @(negedge clk); go = 1'b1;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk); data_in = 8'($urandom);
    end
    @(negedge clk); go = 1'b0; data_in = 8'($urandom);
  endtask

  task automatic load_all(input logic [7:0] a, b, c, y, input int hold);
    load_op(a, hold);
    load_op(b, hold);
    load_op(c, hold);
    load_op(y, hold);
  endtask

  task automatic run_search(input string name, input logic [7:0] a, b, c, y,
                            input int hold, input bit pulse,
                            input int ex, input int ef, input int ec);
    int got;
    bit busy_ok;
    load_all(a, b, c, y, hold);
    got = -1;
    busy_ok = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (done) begin
        got = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      go = pulse && (n % 7 == 3);
    end
    check({name, "_done_cycle"}, got, ec);
    check({name, "_busy_span"}, int'(busy_ok), 1);
    check({name, "_x_result"}, int'(x_result), ex);
    check({name, "_found"}, int'(found), ef);
    // press and release go to return to operand loading
    go = 1'b1;
    @(negedge clk); go = 1'b0;
    check({name, "_done_held"}, int'(done), 1);
    @(negedge clk);
    check({name, "_released"}, int'({done, busy}), 0);
    check({name, "_x_kept"}, int'(x_result), ex);
  endtask

  initial begin
    int ex, ef, ec;
    logic [7:0] a, b, c, y;

    tbl[0] = '{a:8'd1, b:8'd0, c:8'd0, y:8'd9, hold:10, ex:3,   ef:1, ec:20};
    tbl[1] = '{a:8'd0, b:8'd0, c:8'd5, y:8'd5, hold:10, ex:0,   ef:1, ec:5};
    tbl[2] = '{a:8'd0, b:8'd2, c:8'd0, y:8'd1, hold:10, ex:255, ef:0, ec:1280};
    tbl[3] = '{a:8'd2, b:8'd3, c:8'd1, y:8'd6, hold:1,  ex:1,   ef:1, ec:10};
    tbl[4] = '{a:8'd1, b:8'd0, c:8'd0, y:8'd2, hold:2,  ex:255, ef:0, ec:1280};
    tbl[5] = '{a:8'd3, b:8'd0, c:8'd7, y:8'd7, hold:3,  ex:0,   ef:1, ec:5};
    tbl[6] = '{a:8'd1, b:8'd1, c:8'd0, y:8'd6, hold:1,  ex:2,   ef:1, ec:15};

    repeat (3) @(negedge clk);
    check("reset_outputs", int'({x_result, found, done, busy}), 0);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++)
      run_search($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].y,
                 tbl[i].hold, 1'b1, tbl[i].ex, tbl[i].ef, tbl[i].ec);

    // Reset in cycle 100 of an unsolvable search; x_result still holds 2 beforehand.
    load_all(8'd0, 8'd2, 8'd0, 8'd1, 1);
    repeat (101) @(negedge clk);
    check("pre_reset_busy", int'(busy), 1);
    check("pre_reset_x", int'(x_result), 2);
    resetn = 1'b0;
    @(negedge clk); resetn = 1'b1;
    check("mid_reset_x", int'(x_result), 0);
    check("mid_reset_flags", int'({found, done, busy}), 0);
    run_search("post_reset", 8'd1, 8'd1, 8'd0, 8'd2, 1, 1'b0, 1, 1, 10);

    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
      if (i % 2 == 0) begin
        int x0 = int'($urandom_range(0, 255));
        y = 8'((int'(a) * x0 * x0 + int'(b) * x0 + int'(c)) % 256);
      end else begin
        y = 8'($urandom);
      end
      model(int'(a), int'(b), int'(c), int'(y), ex, ef, ec);
      run_search($sformatf("rnd%0d", i), a, b, c, y, int'($urandom_range(1, 4)), 1'b1, ex, ef, ec);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inverse_poly_solver.md
INVERSE_POLY_SOLVER -- requirements
Module: inverse_poly_solver

Interface
REQ-001 The module SHALL have parameter XMAX, default 8'd255: the highest candidate x searched (inclusive).
REQ-002 The module SHALL have port clk, input, 1 bit: the clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-004 The module SHALL have port go, input, 1 bit: operator load/acknowledge strobe, active-high, level-sampled.
REQ-005 The module SHALL have port data_in, input, 8 bits: operand value, captured per the load sequence.
REQ-006 The module SHALL have port x_result, output, 8 bits, registered: the solution, or the last candidate tried.
REQ-007 The module SHALL have port found, output, 1 bit, registered: 1 = x_result satisfies the equation.
REQ-008 The module SHALL have port done, output, 1 bit: 1 while the FSM is in S_DONE or S_DONE_WAIT.
REQ-009 The module SHALL have port busy, output, 1 bit: 1 while the FSM is in any S_EVAL_* or S_CHECK state.

Function
REQ-010 The module SHALL find the smallest x in 0..XMAX such that (A*x*x + B*x + C) mod 256 == Y; all arithmetic is 8-bit, truncated mod 256.
REQ-011 The FSM SHALL load operands in order A, B, C, Y, with states S_LOAD_A, S_LOAD_A_WAIT, ... S_LOAD_Y, S_LOAD_Y_WAIT.
REQ-012 Load behaviour SHALL be:
- In S_LOAD_n, data_in is captured into register n every cycle.
- In S_LOAD_n, go=1 moves the FSM to S_LOAD_n_WAIT.
- In S_LOAD_n_WAIT, the FSM holds while go=1 and advances to the next load state on go=0.
- The register value captured on the cycle go is first seen high is final.
REQ-013 When go=0 in S_LOAD_Y_WAIT, the FSM SHALL enter S_EVAL_0, set the candidate register xc to 0, and clear found.
REQ-014 Each candidate SHALL use one temporary register t and the following per-cycle steps:
- S_EVAL_0: t <= A*xc.
- S_EVAL_1: t <= t+B.
- S_EVAL_2: t <= t*xc.
- S_EVAL_3: t <= t+C.
- S_CHECK: compare t with Y.
REQ-015 In S_CHECK, the FSM SHALL take exactly one of three branches:
- t==Y: x_result <= xc, found <= 1, go to S_DONE.
- t!=Y and xc==XMAX: x_result <= xc, found <= 0, go to S_DONE.
- Otherwise: xc <= xc+1, go to S_EVAL_0.
REQ-016 Timing SHALL be as follows, with cycle 0 = the first S_EVAL_0 cycle:
- Candidate k is checked in cycle 5k+4.
- done rises in cycle 5k+5.
- A search with no solution takes 5*(XMAX+1) cycles before done rises.
REQ-017 xc SHALL never wrap: the increment is suppressed when xc==XMAX.
REQ-018 go SHALL be ignored while busy=1.
REQ-019 In S_DONE, go=1 SHALL move the FSM to S_DONE_WAIT; go=0 there SHALL move it to S_LOAD_A.
REQ-020 x_result and found SHALL hold their values from S_CHECK until the next S_EVAL_0 entry (found cleared) or reset.
REQ-021 A, B, C and Y SHALL remain unchanged from S_LOAD_Y_WAIT exit until the FSM next re-enters their respective load states.
REQ-022 Undefined state encodings SHALL transition to S_LOAD_A.

Reset
REQ-023 resetn=0 at any rising edge, including mid-load or mid-search, SHALL force all of the following on the next cycle:
- FSM: S_LOAD_A.
- A, B, C, Y, t, xc: 0.
- x_result: 0, found: 0, done: 0, busy: 0.
REQ-024 Reset SHALL take priority over go and over every FSM transition.

Verification
REQ-025 The bench SHALL load A=1, B=0, C=0, Y=9 and require x_result=3, found=1, with done rising 20 cycles after S_EVAL_0 entry (x=253 also solves the equation; the smallest solution is required).
REQ-026 The bench SHALL load A=0, B=0, C=5, Y=5 and require x_result=0, found=1, with done rising at cycle 5.
REQ-027 The bench SHALL load A=0, B=2, C=0, Y=1 (no solution, since 2x is always even) and require found=0, x_result=255, with done rising at cycle 1280 and busy=1 throughout cycles 0..1279.
REQ-028 The bench SHALL hold go high for 10 cycles on each load with data_in changed during the hold, and require the values present on the first go-high cycle to be used.
REQ-029 The bench SHALL assert resetn=0 for 1 cycle at cycle 100 of a search and require all outputs to read 0 and the FSM to be in S_LOAD_A on the next cycle; a subsequent full load of A=1, B=1, C=0, Y=2 SHALL yield x_result=1, found=1.
REQ-030 The bench SHALL pulse go during a search and require no effect; after done, a go press-and-release SHALL return the FSM to S_LOAD_A with x_result still holding its value.
